exec_stage: RTL

Execute stage of the SimpleCPU pipeline. It consumes the operand, ALU-op and write-back fields registered by the decode-to-execute pipeline register. It computes the single-cycle ALU result combinationally and owns the HI/LO registers, which are filled by an iterative 32-cycle multiply/divide FSM. While that FSM is busy, the stage raises `stall_req` so the hazard unit freezes fetch, decode and the decode-to-execute register.

---
 rtl/exec_stage_if.sv | 39 +++
 rtl/exec_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_if.sv
// Execute-stage bundle: decode-to-execute fields in, write-back fields, result and stall out.
interface exec_stage_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned PREG_WIDTH      = 6,
  parameter int unsigned FREE_LIST_WIDTH = 3,
  parameter int unsigned ALU_OP_WIDTH    = 5
);
  logic                       flush;
  logic [ADDR_WIDTH-1:0]      pc_in;
  logic [ALU_OP_WIDTH-1:0]    alu_op_in;
  logic [DATA_WIDTH-1:0]      alu_rs_in;
  logic [DATA_WIDTH-1:0]      alu_rt_in;
  logic                       wb_reg_in;
  logic [PREG_WIDTH-1:0]      physical_write_addr_in;
  logic [FREE_LIST_WIDTH-1:0] active_list_index_in;
  logic [DATA_WIDTH-1:0]      result_out;
  logic                       wb_reg_out;
  logic [PREG_WIDTH-1:0]      physical_write_addr_out;
  logic [FREE_LIST_WIDTH-1:0] active_list_index_out;
  logic [ADDR_WIDTH-1:0]      pc_out;
  logic                       stall_req;
  logic [DATA_WIDTH-1:0]      hi_out;
  logic [DATA_WIDTH-1:0]      lo_out;

  modport master (
    output flush, pc_in, alu_op_in, alu_rs_in, alu_rt_in, wb_reg_in,
           physical_write_addr_in, active_list_index_in,
    input  result_out, wb_reg_out, physical_write_addr_out, active_list_index_out,
           pc_out, stall_req, hi_out, lo_out
  );

  modport slave (
    input  flush, pc_in, alu_op_in, alu_rs_in, alu_rt_in, wb_reg_in,
           physical_write_addr_in, active_list_index_in,
    output result_out, wb_reg_out, physical_write_addr_out, active_list_index_out,
           pc_out, stall_req, hi_out, lo_out
  );
endinterface

// File: rtl/exec_stage.sv
// SimpleCPU execute stage: single-cycle ALU plus HI/LO owned by an iterative
// 32-step multiply/divide FSM that stalls the upstream pipeline while busy.
module exec_stage #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned PREG_WIDTH      = 6,
  parameter int unsigned FREE_LIST_WIDTH = 3,
  parameter int unsigned ALU_OP_WIDTH    = 5
) (
  input  logic         clk,
  input  logic         rst,
  exec_stage_if.slave  bus
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned SH_W  = $clog2(DATA_WIDTH);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NOR   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT   = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL   = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL   = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LUI   = ALU_OP_WIDTH'(12);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MULT  = ALU_OP_WIDTH'(13);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MULTU = ALU_OP_WIDTH'(14);
  localparam logic [ALU_OP_WIDTH-1:0] OP_DIV   = ALU_OP_WIDTH'(15);
  localparam logic [ALU_OP_WIDTH-1:0] OP_DIVU  = ALU_OP_WIDTH'(16);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MFHI  = ALU_OP_WIDTH'(17);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MFLO  = ALU_OP_WIDTH'(18);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MTHI  = ALU_OP_WIDTH'(19);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MTLO  = ALU_OP_WIDTH'(20);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DW-1:0]       r_hi;
  logic [DW-1:0]       r_lo;
  logic [2*DW-1:0]     r_acc;
  logic [DW-1:0]       r_opa;
  logic [DW-1:0]       r_rs;
  logic                r_is_div;
  logic                r_neg_a;
  logic                r_neg_b;
  logic                r_div0;

  logic [ALU_OP_WIDTH-1:0] w_op;
  logic [DW-1:0]       w_rs;
  logic [DW-1:0]       w_rt;
  logic                w_is_muldiv;
  logic                w_is_div;
  logic                w_signed;
  logic                w_rs_neg;
  logic                w_rt_neg;
  logic [DW-1:0]       w_rs_mag;
  logic [DW-1:0]       w_rt_mag;
  logic                w_stall;
  logic                w_mt_we;
  logic [DW:0]         w_msum;
  logic [2*DW-1:0]     w_mul_next;
  logic [DW:0]         w_rem_sh;
  logic [DW+1:0]       w_diff;
  logic                w_qbit;
  logic [2*DW-1:0]     w_div_next;
  logic [2*DW-1:0]     w_prod;
  logic [DW-1:0]       w_fin_hi;
  logic [DW-1:0]       w_fin_lo;
  logic [DW-1:0]       w_result;
  logic                w_unused;

  assign w_op = bus.alu_op_in;
  assign w_rs = bus.alu_rs_in;
  assign w_rt = bus.alu_rt_in;

  assign w_is_muldiv = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                       (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_is_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_signed    = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_rs_neg    = w_signed & w_rs[DW-1];
  assign w_rt_neg    = w_signed & w_rt[DW-1];
  assign w_rs_mag    = w_rs_neg ? DW'(-w_rs) : w_rs;
  assign w_rt_mag    = w_rt_neg ? DW'(-w_rt) : w_rt;

  assign w_stall = ((r_state == S_IDLE) & w_is_muldiv & ~bus.flush) |
                   ((r_state == S_BUSY) & ~bus.flush);
  assign w_mt_we = ~w_stall & ~bus.flush;

  // Shift-add multiply step: acc = {partial product, remaining multiplier}.
  assign w_msum     = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_opa} : (DW+1)'(0));
  assign w_mul_next = {w_msum, r_acc[DW-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  assign w_rem_sh   = r_acc[2*DW-1:DW-1];
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opa};
  assign w_qbit     = ~w_diff[DW+1];
  assign w_div_next = {(w_qbit ? w_diff[DW-1:0] : w_rem_sh[DW-1:0]), r_acc[DW-2:0], w_qbit};
  assign w_unused   = w_diff[DW];

  assign w_prod = r_neg_a ? (2*DW)'(-w_mul_next) : w_mul_next;

  // Sign fix-up and the divide-by-zero convention applied on the final step.
  always_comb begin
    w_fin_hi = w_prod[2*DW-1:DW];
    w_fin_lo = w_prod[DW-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fin_hi = r_rs;
        w_fin_lo = '1;
      end else begin
        w_fin_lo = r_neg_a ? DW'(-w_div_next[DW-1:0])    : w_div_next[DW-1:0];
        w_fin_hi = r_neg_b ? DW'(-w_div_next[2*DW-1:DW]) : w_div_next[2*DW-1:DW];
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_ADD:  w_result = w_rs + w_rt;
      OP_SUB:  w_result = w_rs - w_rt;
      OP_AND:  w_result = w_rs & w_rt;
      OP_OR:   w_result = w_rs | w_rt;
      OP_XOR:  w_result = w_rs ^ w_rt;
      OP_NOR:  w_result = ~(w_rs | w_rt);
      OP_SLT:  w_result = DW'($signed(w_rs) < $signed(w_rt));
      OP_SLTU: w_result = DW'(w_rs < w_rt);
      OP_SLL:  w_result = w_rt << w_rs[SH_W-1:0];
      OP_SRL:  w_result = w_rt >> w_rs[SH_W-1:0];
      OP_SRA:  w_result = DW'($signed(w_rt) >>> w_rs[SH_W-1:0]);
      OP_LUI:  w_result = w_rt << 16;
      OP_MFHI: w_result = r_hi;
      OP_MFLO: w_result = r_lo;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_rs     <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      if (w_mt_we && (w_op == OP_MTHI)) r_hi <= w_rs;
      if (w_mt_we && (w_op == OP_MTLO)) r_lo <= w_rs;
      case (r_state)
        S_IDLE: begin
          if (w_is_muldiv && !bus.flush) begin
            r_is_div <= w_is_div;
            r_opa    <= w_is_div ? w_rt_mag : w_rs_mag;
            r_acc    <= {DW'(0), (w_is_div ? w_rs_mag : w_rt_mag)};
            r_neg_a  <= w_rs_neg ^ w_rt_neg;
            r_neg_b  <= w_rs_neg;
            r_div0   <= (w_rt == '0);
            r_rs     <= w_rs;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DW - 1)) begin
              r_hi    <= w_fin_hi;
              r_lo    <= w_fin_lo;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result_out              = w_result;
  assign bus.wb_reg_out              = bus.wb_reg_in & ~w_stall & ~bus.flush;
  assign bus.physical_write_addr_out = bus.physical_write_addr_in;
  assign bus.active_list_index_out   = bus.active_list_index_in;
  assign bus.pc_out                  = bus.pc_in;
  assign bus.stall_req               = w_stall;
  assign bus.hi_out                  = r_hi;
  assign bus.lo_out                  = r_lo;
endmodule
